// File: rtl/brg_xcel_arb_pkg.sv
// Shared types and helpers for the xcel master-side arbiter and its
// round-robin picker.
package brg_xcel_arb_pkg;

    typedef enum logic {
        eRun   = 1'b0,
        eDrain = 1'b1
    } arb_state_e;

    // Tag width for n requesters; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/brg_xcel_rr_picker.sv
// Combinational round-robin picker: first eligible index at or after
// rr_ptr_i, modulo num_req_p, returned both one-hot and encoded.
module brg_xcel_rr_picker #(
    parameter int unsigned num_req_p    = 4,
    parameter int unsigned idx_width_lp = 2
) (
    input  logic [num_req_p-1:0]    eligible_i,
    input  logic [idx_width_lp-1:0] rr_ptr_i,
    output logic [num_req_p-1:0]    grant_oh_o,
    output logic [idx_width_lp-1:0] grant_idx_o,
    output logic                    grant_v_o
);

    int unsigned               cand;
    logic [idx_width_lp-1:0]   cand_idx;

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        grant_v_o   = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        // Walk from the farthest offset down so the nearest eligible wins.
        for (int unsigned k = num_req_p; k > 0; k--) begin
            cand = 32'(rr_ptr_i) + k - 1;
            if (cand >= num_req_p) begin
                cand = cand - num_req_p;
            end
            cand_idx = idx_width_lp'(cand);
            if (eligible_i[cand_idx]) begin
                grant_v_o            = 1'b1;
                grant_oh_o           = '0;
                grant_oh_o[cand_idx] = 1'b1;
                grant_idx_o          = cand_idx;
            end
        end
    end

endmodule

// File: rtl/brg_xcel_master_arbiter.sv
// Shares one endpoint master port among num_req_p accelerator requesters:
// round-robin grant, load_id tagging, response steering, credits, drain.
module brg_xcel_master_arbiter
    import brg_xcel_arb_pkg::*;
#(
    parameter int unsigned num_req_p       = 4,
    parameter int unsigned addr_width_p    = 32,
    parameter int unsigned data_width_p    = 32,
    parameter int unsigned load_id_width_p = 11,
    parameter int unsigned max_out_loads_p = 16,
    localparam int unsigned idx_width_lp     = idx_width(num_req_p),
    localparam int unsigned req_opq_width_lp = load_id_width_p - idx_width_lp,
    localparam int unsigned mask_width_lp    = data_width_p >> 3
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,

    input  logic [num_req_p-1:0]                  req_v_i,
    input  logic [num_req_p-1:0]                  req_type_i,
    input  logic [num_req_p*addr_width_p-1:0]     req_addr_i,
    input  logic [num_req_p*data_width_p-1:0]     req_data_i,
    input  logic [num_req_p*mask_width_lp-1:0]    req_mask_i,
    input  logic [num_req_p*req_opq_width_lp-1:0] req_opq_i,
    output logic [num_req_p-1:0]                  req_ready_o,

    output logic                                  out_v_o,
    output logic                                  out_type_o,
    output logic [addr_width_p-1:0]               out_addr_o,
    output logic [data_width_p-1:0]               out_data_o,
    output logic [mask_width_lp-1:0]              out_mask_o,
    output logic [load_id_width_p-1:0]            out_opq_o,
    input  logic                                  out_ready_i,

    input  logic                                  ret_v_i,
    input  logic [load_id_width_p-1:0]            ret_opq_i,
    input  logic [data_width_p-1:0]               ret_data_i,
    output logic [num_req_p-1:0]                  resp_v_o,
    output logic [req_opq_width_lp-1:0]           resp_opq_o,
    output logic [data_width_p-1:0]               resp_data_o,

    input  logic                                  drain_i,
    output logic                                  idle_o,
    output logic                                  err_o
);

    localparam int unsigned cnt_width_lp = $clog2(max_out_loads_p + 1);

    arb_state_e                 state_q, state_d;
    logic [idx_width_lp-1:0]    rr_ptr_q, rr_ptr_d;
    logic [idx_width_lp-1:0]    lock_idx_q, lock_idx_d;
    logic                       lock_v_q, lock_v_d;
    logic                       err_q, err_d;
    logic [cnt_width_lp-1:0]    cnt_q [num_req_p];
    logic [cnt_width_lp-1:0]    cnt_d [num_req_p];

    logic [num_req_p-1:0]       eligible;
    logic [num_req_p-1:0]       pick_oh;
    logic [idx_width_lp-1:0]    pick_idx;
    logic                       pick_v;

    logic [num_req_p-1:0]       grant_oh;
    logic [idx_width_lp-1:0]    grant_idx;
    logic                       grant_v;
    logic                       accept;

    logic [idx_width_lp-1:0]    ret_idx;
    logic [num_req_p-1:0]       resp_v;
    logic                       ret_good;
    logic                       cnt_all_zero;

    logic                       mux_type;
    logic [addr_width_p-1:0]    mux_addr;
    logic [data_width_p-1:0]    mux_data;
    logic [mask_width_lp-1:0]   mux_mask;
    logic [req_opq_width_lp-1:0] mux_opq;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            eligible[i] = req_v_i[i] &
                          (req_type_i[i] | (cnt_q[i] < cnt_width_lp'(max_out_loads_p)));
        end
    end

    brg_xcel_rr_picker #(
        .num_req_p    (num_req_p),
        .idx_width_lp (idx_width_lp)
    ) u_picker (
        .eligible_i  (eligible),
        .rr_ptr_i    (rr_ptr_q),
        .grant_oh_o  (pick_oh),
        .grant_idx_o (pick_idx),
        .grant_v_o   (pick_v)
    );

    // A locked grant overrides arbitration and survives into eDrain.
    always_comb begin
        grant_oh  = '0;
        grant_idx = pick_idx;
        grant_v   = 1'b0;
        if (lock_v_q) begin
            grant_v   = 1'b1;
            grant_idx = lock_idx_q;
            for (int unsigned i = 0; i < num_req_p; i++) begin
                grant_oh[i] = (lock_idx_q == idx_width_lp'(i));
            end
        end else if (state_q == eRun) begin
            grant_v   = pick_v;
            grant_idx = pick_idx;
            grant_oh  = pick_oh;
        end
        accept = grant_v & out_ready_i;
    end

    always_comb begin
        mux_type = 1'b0;
        mux_addr = '0;
        mux_data = '0;
        mux_mask = '0;
        mux_opq  = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            if (grant_idx == idx_width_lp'(i)) begin
                mux_type = req_type_i[i];
                mux_addr = req_addr_i[i*addr_width_p +: addr_width_p];
                mux_data = req_data_i[i*data_width_p +: data_width_p];
                mux_mask = req_mask_i[i*mask_width_lp +: mask_width_lp];
                mux_opq  = req_opq_i[i*req_opq_width_lp +: req_opq_width_lp];
            end
        end
    end

    // An index outside the requester range never matches, so it lands as an error.
    always_comb begin
        ret_idx  = ret_opq_i[load_id_width_p-1 -: idx_width_lp];
        resp_v   = '0;
        ret_good = 1'b0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            if (ret_v_i && (ret_idx == idx_width_lp'(i)) && (cnt_q[i] != '0)) begin
                resp_v[i] = 1'b1;
                ret_good  = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_all_zero = 1'b1;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_q[i] != '0) begin
                cnt_all_zero = 1'b0;
            end
            if (accept && !mux_type && (grant_idx == idx_width_lp'(i))) begin
                if (!resp_v[i]) begin
                    cnt_d[i] = cnt_q[i] + cnt_width_lp'(1);
                end
            end else if (resp_v[i]) begin
                cnt_d[i] = cnt_q[i] - cnt_width_lp'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_v_d   = lock_v_q;
        lock_idx_d = lock_idx_q;
        err_d      = err_q | (ret_v_i & ~ret_good);

        unique case (state_q)
            eRun:    if (drain_i)  state_d = eDrain;
            eDrain:  if (!drain_i) state_d = eRun;
            default: state_d = eRun;
        endcase

        if (grant_v && !out_ready_i) begin
            lock_v_d   = 1'b1;
            lock_idx_d = grant_idx;
        end else if (accept) begin
            lock_v_d = 1'b0;
            rr_ptr_d = (grant_idx == idx_width_lp'(num_req_p - 1)) ? '0
                                                                   : grant_idx + idx_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= eRun;
            rr_ptr_q   <= '0;
            lock_v_q   <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
            for (int unsigned i = 0; i < num_req_p; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_v_q   <= lock_v_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
            for (int unsigned i = 0; i < num_req_p; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        out_v_o     = 1'b0;
        out_type_o  = 1'b0;
        out_addr_o  = '0;
        out_data_o  = '0;
        out_mask_o  = '0;
        out_opq_o   = '0;
        resp_v_o    = '0;
        resp_opq_o  = '0;
        resp_data_o = '0;
        idle_o      = 1'b0;
        err_o       = 1'b0;
        if (reset_n_i) begin
            req_ready_o = out_ready_i ? grant_oh : '0;
            out_v_o     = grant_v;
            out_type_o  = mux_type;
            out_addr_o  = mux_addr;
            out_data_o  = mux_data;
            out_mask_o  = mux_mask;
            out_opq_o   = {grant_idx, mux_opq};
            resp_v_o    = resp_v;
            resp_opq_o  = ret_opq_i[req_opq_width_lp-1:0];
            resp_data_o = ret_data_i;
            idle_o      = (state_q == eDrain) & ~lock_v_q & cnt_all_zero;
            err_o       = err_q;
        end
    end

endmodule
